// File: rtl/serial_subtractor.sv
// ============================================================================
// Module   : serial_subtractor
// Brief    : Bit-serial N-bit subtractor (a - b), LSB first, one borrow flop,
//            with per-stage borrow outputs and a start/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic [N-1:0] bo,
  output logic         neg
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t        r_state;
  logic [N-1:0]  r_sa;
  logic [N-1:0]  r_sb;
  logic          r_borrow;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_diff;
  logic [N-1:0]  r_bo;
  logic          r_neg;

  logic          w_d;
  logic          w_borrow_next;

  // Full-subtractor cell applied to the current LSBs of the shifting operands.
  assign w_d           = r_sa[0] ^ r_sb[0] ^ r_borrow;
  assign w_borrow_next = (~r_sa[0] & r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_borrow);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_sa     <= '0;
      r_sb     <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_diff   <= '0;
      r_bo     <= '0;
      r_neg    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sa     <= a;
            r_sb     <= b;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_bo     <= '0;
            r_neg    <= 1'b0;
            r_state  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // Result bits enter at the MSB so bit 0 lands at diff[0] after N shifts.
          r_diff       <= {w_d, r_diff[N-1:1]};
          r_bo[r_cnt]  <= w_borrow_next;
          r_borrow     <= w_borrow_next;
          r_sa         <= {1'b0, r_sa[N-1:1]};
          r_sb         <= {1'b0, r_sb[N-1:1]};
          if (r_cnt == C_LAST) begin
            r_neg   <= w_borrow_next;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);
  assign diff = r_diff;
  assign bo   = r_bo;
  assign neg  = r_neg;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// Module   : tb_serial_subtractor
// Brief    : Self-checking bench for serial_subtractor against an arithmetic
//            reference model (modular difference and prefix comparisons).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

  localparam int N = 4;
  localparam int MASK = (1 << N) - 1;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] diff;
  logic [N-1:0] bo;
  logic         neg;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  serial_subtractor #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bo    (bo),
    .neg   (neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Borrow out of stage i happens exactly when the low i+1 bits of a are smaller than those of b.
  function automatic logic [N-1:0] model_bo(input int ma, input int mb);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) begin
      int m;
      m = (1 << (i + 1)) - 1;
      r[i] = ((ma & m) < (mb & m));
    end
    return r;
  endfunction

  task automatic check_result(input string tag, input int ma, input int mb);
    check_value({tag, "_diff"}, 32'(diff), 32'((ma - mb) & MASK));
    check_value({tag, "_bo"},   32'(bo),   32'(model_bo(ma, mb)));
    check_value({tag, "_neg"},  32'(neg),  32'(ma < mb));
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
    end while (!done && edges < 40);
    if (!done) check_value("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic run_op(input string tag, input int ma, input int mb);
    int e;
    @(negedge clk);
    a = N'(ma); b = N'(mb); start = 1'b1;
    @(posedge clk); #1;
    check_value({tag, "_accept_busy"}, 32'(busy), 32'd1);
    check_value({tag, "_accept_diff_clr"}, 32'(diff), 32'd0);
    start = 1'b0;
    a = N'($urandom); b = N'($urandom);
    wait_done(e);
    check_value({tag, "_latency"}, 32'(e), 32'(N));
    check_value({tag, "_done_busy"}, 32'(busy), 32'd1);
    check_result(tag, ma, mb);
    @(posedge clk); #1;
    check_value({tag, "_post_busy"}, 32'(busy), 32'd0);
    check_value({tag, "_post_done"}, 32'(done), 32'd0);
    check_result({tag, "_hold"}, ma, mb);
  endtask

  initial begin
    int e;
    int ndone;
    int order[256];
    int prev_acc;
    int cur_a, cur_b;

    rst = 1'b1; start = 1'b0; a = '0; b = '0;

    // Reset, then idle with start low
    repeat (2) @(posedge clk);
    #1;
    check_value("rst_busy", 32'(busy), 32'd0);
    check_value("rst_done", 32'(done), 32'd0);
    check_value("rst_diff", 32'(diff), 32'd0);
    check_value("rst_bo",   32'(bo),   32'd0);
    check_value("rst_neg",  32'(neg),  32'd0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      a = N'($urandom); b = N'($urandom);
      @(posedge clk); #1;
      check_value("idle_busy", 32'(busy), 32'd0);
      check_value("idle_done", 32'(done), 32'd0);
      check_value("idle_diff", 32'(diff), 32'd0);
    end

    // Directed cases, with explicit constants for the first one
    run_op("d9m4", 9, 4);
    check_value("d9m4_const_diff", 32'(diff), 32'b0101);
    check_value("d9m4_const_bo",   32'(bo),   32'b0100);
    run_op("d4m9", 4, 9);
    check_value("d4m9_const_bo", 32'(bo), 32'b1011);
    run_op("d0m15", 0, 15);
    run_op("d0m0", 0, 0);

    // Start pulses during SHIFT and DONE must be ignored
    @(negedge clk);
    a = 4'd9; b = 4'd4; start = 1'b1;
    @(posedge clk); #1;
    check_value("ign_accept", 32'(busy), 32'd1);
    @(negedge clk); a = 4'd1; b = 4'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    ndone = 0;
    e = 1;
    do begin
      @(posedge clk); #1;
      e++;
    end while (!done && e < 40);
    check_value("ign_latency", 32'(e), 32'(N));
    if (done) ndone++;
    start = 1'b1; a = 4'd1; b = 4'd1;
    @(posedge clk); #1;
    start = 1'b0;
    check_value("ign_busy_after_done", 32'(busy), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
      check_value("ign_stays_idle", 32'(busy), 32'd0);
    end
    check_value("ign_done_count", 32'(ndone), 32'd1);
    check_result("ign", 9, 4);

    // Reset mid-operation aborts without a done
    @(negedge clk);
    a = 4'd12; b = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b1; #1;
    check_value("abort_busy", 32'(busy), 32'd0);
    check_value("abort_done", 32'(done), 32'd0);
    check_value("abort_diff", 32'(diff), 32'd0);
    check_value("abort_bo",   32'(bo),   32'd0);
    check_value("abort_neg",  32'(neg),  32'd0);
    @(negedge clk); rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check_value("abort_no_done", 32'(ndone), 32'd0);
    run_op("after_abort", 12, 3);

    // Random operands with random idle gaps
    for (int t = 0; t < 30; t++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      run_op("rand", int'($urandom_range(0, MASK)), int'($urandom_range(0, MASK)));
    end

    // Exhaustive, shuffled, back to back with start held high
    for (int i = 0; i < 256; i++) order[i] = i;
    for (int i = 255; i > 0; i--) begin
      int j, tmp;
      j = int'($urandom_range(0, i));
      tmp = order[i]; order[i] = order[j]; order[j] = tmp;
    end
    @(negedge clk);
    start = 1'b1;
    a = N'(order[0] >> N); b = N'(order[0] & MASK);
    prev_acc = -1;
    for (int p = 0; p < 256; p++) begin
      e = 0;
      do begin
        @(posedge clk); #1;
        e++;
      end while (!busy && e < 10);
      if (!busy) check_value("exh_accept_timeout", 32'(busy), 32'd1);
      if (prev_acc >= 0) check_value("exh_spacing", 32'(cyc - prev_acc), 32'(N + 2));
      prev_acc = cyc;
      cur_a = int'(a); cur_b = int'(b);
      if (p < 255) begin
        a = N'(order[p + 1] >> N); b = N'(order[p + 1] & MASK);
      end else begin
        start = 1'b0;
      end
      wait_done(e);
      check_value("exh_latency", 32'(e), 32'(N));
      check_result("exh", cur_a, cur_b);
    end
    start = 1'b0;
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
